// File: rtl/updn_bcd_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updn_bcd_counter                                             |
// | Description : Binary up/down counter with combinational BCD digit decode.  |
// |               Define UPDN_SATURATE_EN to saturate at the limits instead of |
// |               wrapping (WRAP then flags a saturation hit).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module updn_bcd_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             UPDN,
    output logic [WIDTH-1:0] VALUE,
    output logic [3:0]       HUNDREDS,
    output logic [3:0]       TENS,
    output logic [3:0]       ONES,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
            $error("updn_bcd_counter: WIDTH must be in 1..8");
        end
    endgenerate

    logic [WIDTH-1:0] r_value;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_wrap;
    logic [11:0]      w_bcd;

    always_comb begin
        w_next_value = r_value;
        w_next_wrap  = 1'b0;
        if (ENABLE) begin
            if (UPDN) begin
                w_next_wrap = (r_value == c_max);
`ifdef UPDN_SATURATE_EN
                if (r_value != c_max) begin
                    w_next_value = r_value + c_one;
                end
`else
                w_next_value = r_value + c_one;
`endif
            end else begin
                w_next_wrap = (r_value == c_zero);
`ifdef UPDN_SATURATE_EN
                if (r_value != c_zero) begin
                    w_next_value = r_value - c_one;
                end
`else
                w_next_value = r_value - c_one;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_value <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_wrap  <= w_next_wrap;
        end
    end

    // Double dabble: correct any digit >= 5 before shifting in the next bit.
    always_comb begin
        w_bcd = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_bcd[3:0] >= 4'd5) begin
                w_bcd[3:0] = w_bcd[3:0] + 4'd3;
            end
            if (w_bcd[7:4] >= 4'd5) begin
                w_bcd[7:4] = w_bcd[7:4] + 4'd3;
            end
            if (w_bcd[11:8] >= 4'd5) begin
                w_bcd[11:8] = w_bcd[11:8] + 4'd3;
            end
            w_bcd = {w_bcd[10:0], r_value[i]};
        end
    end

    assign VALUE    = r_value;
    assign WRAP     = r_wrap;
    assign HUNDREDS = w_bcd[11:8];
    assign TENS     = w_bcd[7:4];
    assign ONES     = w_bcd[3:0];

endmodule
`default_nettype wire

// File: tb/tb_updn_bcd_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_updn_bcd_counter                                          |
// | Description : Directed table-driven bench for updn_bcd_counter (4 and 8    |
// |               bit instances); 8-bit limit checks honour UPDN_SATURATE_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_updn_bcd_counter;

    logic       clk;
    logic       rst;
    logic       en4, updn4, en8, updn8;
    logic [3:0] value4;
    logic [3:0] hun4, tens4, ones4;
    logic       wrap4;
    logic [7:0] value8;
    logic [3:0] hun8, tens8, ones8;
    logic       wrap8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic en;
        logic updn;
        int   v;
        int   w;
    } vec_t;

    vec_t vecs[$];

    updn_bcd_counter #(.WIDTH(4)) u_dut4 (
        .CLK(clk), .RST(rst), .ENABLE(en4), .UPDN(updn4),
        .VALUE(value4), .HUNDREDS(hun4), .TENS(tens4), .ONES(ones4), .WRAP(wrap4)
    );

    updn_bcd_counter #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .ENABLE(en8), .UPDN(updn8),
        .VALUE(value8), .HUNDREDS(hun8), .TENS(tens8), .ONES(ones8), .WRAP(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check4(input string tag, input int v, input int w);
        check({tag, " value4"}, int'(value4), v);
        check({tag, " hundreds4"}, int'(hun4), 0);
        check({tag, " tens4"}, int'(tens4), v / 10);
        check({tag, " ones4"}, int'(ones4), v % 10);
        check({tag, " wrap4"}, int'(wrap4), w);
    endtask

    task automatic check8(input string tag, input int v, input int h, input int t,
                          input int o, input int w);
        check({tag, " value8"}, int'(value8), v);
        check({tag, " hundreds8"}, int'(hun8), h);
        check({tag, " tens8"}, int'(tens8), t);
        check({tag, " ones8"}, int'(ones8), o);
        check({tag, " wrap8"}, int'(wrap8), w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic updn, input int v, input int w);
        vec_t r;
        r.en = en; r.updn = updn; r.v = v; r.w = w;
        vecs.push_back(r);
    endtask

    initial begin
        // Up 17 edges from 0: 1..15, 0 (wrap), 1; one more up to reach 2.
        for (int k = 1; k <= 15; k++) add(1'b1, 1'b1, k, 0);
        add(1'b1, 1'b1, 0, 1);
        add(1'b1, 1'b1, 1, 0);
        add(1'b1, 1'b1, 2, 0);
        // Down through zero.
        add(1'b1, 1'b0, 1, 0);
        add(1'b1, 1'b0, 0, 0);
        add(1'b1, 1'b0, 15, 1);
        add(1'b1, 1'b0, 14, 0);
        for (int k = 13; k >= 7; k--) add(1'b1, 1'b0, k, 0);
        // Hold at 7 while UPDN toggles, then immediate down step.
        for (int k = 0; k < 5; k++) add(1'b0, k[0], 7, 0);
        add(1'b1, 1'b0, 6, 0);
        // Reverse direction with no dead cycle, up to 12.
        for (int k = 7; k <= 12; k++) add(1'b1, 1'b1, k, 0);

        rst = 1'b0; en4 = 1'b1; updn4 = 1'b1; en8 = 1'b0; updn8 = 1'b1;
        #1;
        check4("reset t0", 0, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            check4("reset held", 0, 0);
        end
        rst = 1'b1;

        foreach (vecs[i]) begin
            en4   = vecs[i].en;
            updn4 = vecs[i].updn;
            step();
            check4($sformatf("vec%0d", i), vecs[i].v, vecs[i].w);
        end

        // Asynchronous reset between edges, held across an edge.
        #3;
        rst = 1'b0;
        #1;
        check4("async reset", 0, 0);
        en4 = 1'b1; updn4 = 1'b1;
        step();
        check4("reset dominates", 0, 0);
        #2;
        rst = 1'b1;
        step();
        check4("post reset", 1, 0);

        // 8-bit instance: limits and 3-digit decode.
        en4 = 1'b0;
        en8 = 1'b1; updn8 = 1'b0;
        step();
`ifdef UPDN_SATURATE_EN
        check8("8b down at 0", 0, 0, 0, 0, 1);
        updn8 = 1'b1;
        step();
        check8("8b up", 1, 0, 0, 1, 0);
        for (int k = 0; k < 99; k++) step();
`else
        check8("8b down at 0", 255, 2, 5, 5, 1);
        updn8 = 1'b1;
        step();
        check8("8b wrap up", 0, 0, 0, 0, 1);
        for (int k = 0; k < 100; k++) step();
`endif
        check8("8b 100", 100, 1, 0, 0, 0);
        for (int k = 0; k < 155; k++) step();
        check8("8b 255", 255, 2, 5, 5, 0);
        step();
`ifdef UPDN_SATURATE_EN
        check8("8b sat up", 255, 2, 5, 5, 1);
`else
        check8("8b wrap 255", 0, 0, 0, 0, 1);
`endif
        en8 = 1'b0;
        step();
`ifdef UPDN_SATURATE_EN
        check8("8b hold", 255, 2, 5, 5, 0);
`else
        check8("8b hold", 0, 0, 0, 0, 0);
`endif
        check4("4b held", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
